// File: rtl/pspin_pkt_alloc_mc_if.sv
// Ingress allocator handshakes: packet request in, slot release in, DMA write request out.
// The slave modport is the allocator side; master is whoever drives requests and sinks writes.
interface pspin_pkt_alloc_mc_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 20,
  parameter int TAG_WIDTH  = 32
);
  logic [TAG_WIDTH-1:0]  pkt_tag_i;
  logic [LEN_WIDTH-1:0]  pkt_len_i;
  logic                  pkt_valid_i;
  logic                  pkt_ready_o;
  logic                  feedback_valid_i;
  logic                  feedback_ready_o;
  logic [ADDR_WIDTH-1:0] feedback_addr_i;
  logic [ADDR_WIDTH-1:0] write_addr_o;
  logic [LEN_WIDTH-1:0]  write_len_o;
  logic [TAG_WIDTH-1:0]  write_tag_o;
  logic                  write_valid_o;
  logic                  write_ready_i;

  modport master (
    output pkt_tag_i, pkt_len_i, pkt_valid_i, feedback_valid_i, feedback_addr_i, write_ready_i,
    input  pkt_ready_o, feedback_ready_o, write_addr_o, write_len_o, write_tag_o, write_valid_o
  );
  modport slave (
    input  pkt_tag_i, pkt_len_i, pkt_valid_i, feedback_valid_i, feedback_addr_i, write_ready_i,
    output pkt_ready_o, feedback_ready_o, write_addr_o, write_len_o, write_tag_o, write_valid_o
  );
endinterface

// File: rtl/pspin_pkt_alloc_mc.sv
// Multi-class packet slot allocator: per-class free FIFOs of slot addresses, smallest-fit
// selection with optional upward fallback, address-decoded release and saturating stats.
module pspin_pkt_alloc_mc_fifo #(
  parameter int DEPTH = 2,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [PW-1:0] incr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (pop_i)  rd_ptr_d = incr(rd_ptr_q);
    if (push_i) wr_ptr_d = incr(wr_ptr_q);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) if (push_i) mem_q[wr_ptr_q] <= push_data_i;

  assign head_o = mem_q[rd_ptr_q];
endmodule

module pspin_pkt_alloc_mc #(
  parameter int NUM_CLASSES = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int LEN_WIDTH   = 20,
  parameter int TAG_WIDTH   = 32,
  parameter int CNT_WIDTH   = 16,
  parameter logic [ADDR_WIDTH-1:0] BUF_START = 'h1c100000,
  parameter longint unsigned BUF_SIZE = 1048576,
  parameter logic [NUM_CLASSES*LEN_WIDTH-1:0] CLASS_SIZE  = {20'd4096, 20'd1536, 20'd256, 20'd64},
  parameter logic [NUM_CLASSES*CNT_WIDTH-1:0] CLASS_COUNT = {16'd32, 16'd256, 16'd512, 16'd2048},
  parameter int ALIGNMENT   = 64,
  parameter bit FALLBACK_EN = 1'b1
) (
  input  logic                             clk,
  input  logic                             rstn,
  pspin_pkt_alloc_mc_if.slave              bus,
  output logic                             init_done_o,
  output logic [NUM_CLASSES*CNT_WIDTH-1:0] free_count_o,
  output logic [31:0]                      dropped_pkts_o,
  output logic [31:0]                      fallback_pkts_o,
  output logic [31:0]                      bad_feedback_o
);
  localparam int NC = NUM_CLASSES;

  function automatic logic [LEN_WIDTH-1:0] csize(input int k);
    return CLASS_SIZE[k*LEN_WIDTH +: LEN_WIDTH];
  endfunction
  function automatic logic [CNT_WIDTH-1:0] ccount(input int k);
    return CLASS_COUNT[k*CNT_WIDTH +: CNT_WIDTH];
  endfunction
  function automatic logic [ADDR_WIDTH-1:0] rstart(input int k);
    logic [ADDR_WIDTH-1:0] a;
    a = BUF_START;
    for (int j = 0; j < k; j++) a = a + ADDR_WIDTH'(csize(j)) * ADDR_WIDTH'(ccount(j));
    return a;
  endfunction
  function automatic longint unsigned total_bytes();
    longint unsigned t;
    t = 0;
    for (int j = 0; j < NC; j++) t = t + longint'(csize(j)) * longint'(ccount(j));
    return t;
  endfunction
  function automatic int max_count();
    int m;
    m = 0;
    for (int j = 0; j < NC; j++) if (int'(ccount(j)) > m) m = int'(ccount(j));
    return m;
  endfunction
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && v != '1) ? v + 32'd1 : v;
  endfunction

  localparam int MAX_COUNT = max_count();

  if (NC < 1 || NC > 8) begin : g_err_nc
    $error("NUM_CLASSES must be 1..8");
  end
  if (ALIGNMENT <= 0 || (ALIGNMENT & (ALIGNMENT-1)) != 0) begin : g_err_align
    $error("ALIGNMENT must be a power of two");
  end
  if (total_bytes() > BUF_SIZE) begin : g_err_size
    $error("class regions exceed BUF_SIZE");
  end

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e                             state_q, state_d;
  logic [CNT_WIDTH-1:0]               init_cnt_q, init_cnt_d;
  logic [NC-1:0][ADDR_WIDTH-1:0]      init_addr_q, init_addr_d;
  logic [NC-1:0][CNT_WIDTH-1:0]       cnt_q, cnt_d;
  logic [NC-1:0][ADDR_WIDTH-1:0]      start_a, end_a, head, push_data;
  logic [NC-1:0]                      push, pop;
  logic                               wv_q, wv_d;
  logic [ADDR_WIDTH-1:0]              waddr_q, waddr_d;
  logic [LEN_WIDTH-1:0]               wlen_q, wlen_d;
  logic [TAG_WIDTH-1:0]               wtag_q, wtag_d;
  logic [31:0]                        drop_q, drop_d, fbk_q, fbk_d, bad_q, bad_d;
  logic                               pkt_rdy, pkt_acc, fb_acc;
  int                                 pref, sel_k, fb_k;
  logic                               pref_ok, sel_ok, sel_fb, fb_ok;
  logic [ADDR_WIDTH-1:0]              sel_addr;
  logic [LEN_WIDTH-1:0]               sel_len;

  for (genvar k = 0; k < NC; k++) begin : g_cls
    assign start_a[k] = rstart(k);
    assign end_a[k]   = rstart(k+1);
    if (ccount(k) == '0) begin : g_err_cnt
      $error("CLASS_COUNT entries must be nonzero");
    end
    if ((int'(csize(k)) % ALIGNMENT) != 0) begin : g_err_mult
      $error("CLASS_SIZE entries must be multiples of ALIGNMENT");
    end
    if (k > 0) begin : g_ord
      if (csize(k) <= csize(k-1)) begin : g_err_asc
        $error("CLASS_SIZE must be strictly ascending");
      end
    end
    pspin_pkt_alloc_mc_fifo #(.DEPTH(int'(ccount(k))), .DW(ADDR_WIDTH)) u_fifo (
      .clk(clk), .rstn(rstn), .push_i(push[k]), .push_data_i(push_data[k]),
      .pop_i(pop[k]), .head_o(head[k])
    );
  end

  assign init_done_o          = (state_q == S_RUN);
  assign pkt_rdy              = init_done_o && (!wv_q || bus.write_ready_i);
  assign pkt_acc              = bus.pkt_valid_i && pkt_rdy;
  assign fb_acc               = bus.feedback_valid_i && init_done_o;
  assign bus.pkt_ready_o      = pkt_rdy;
  assign bus.feedback_ready_o = init_done_o;

  always_comb begin
    state_d = state_q; init_cnt_d = init_cnt_q; init_addr_d = init_addr_q;
    push = '0; pop = '0; push_data = '0;
    pref = 0; pref_ok = 1'b0; sel_k = 0; sel_ok = 1'b0; sel_fb = 1'b0;
    sel_addr = '0; sel_len = '0; fb_k = 0; fb_ok = 1'b0;
    if (state_q == S_INIT) begin
      for (int k = 0; k < NC; k++) begin
        if (init_cnt_q < ccount(k)) begin
          push[k]        = 1'b1;
          push_data[k]   = init_addr_q[k];
          init_addr_d[k] = init_addr_q[k] + ADDR_WIDTH'(csize(k));
        end
      end
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == CNT_WIDTH'(MAX_COUNT-1)) state_d = S_RUN;
    end
    // Descending scan leaves the smallest fitting class in pref.
    for (int k = NC-1; k >= 0; k--) begin
      if (csize(k) >= bus.pkt_len_i) begin
        pref_ok = 1'b1;
        pref    = k;
      end
    end
    for (int k = 0; k < NC; k++) begin
      if (!sel_ok && pref_ok && cnt_q[k] != '0 && (k == pref || (FALLBACK_EN && k > pref))) begin
        sel_ok   = 1'b1;
        sel_k    = k;
        sel_fb   = (k != pref);
        sel_addr = head[k];
        sel_len  = csize(k);
      end
    end
    for (int k = 0; k < NC; k++) begin
      pop[k] = pkt_acc && sel_ok && (sel_k == k);
      if (bus.feedback_addr_i >= start_a[k] && bus.feedback_addr_i < end_a[k]) begin
        fb_k  = k;
        fb_ok = ((bus.feedback_addr_i - start_a[k]) % ADDR_WIDTH'(csize(k))) == '0
                && cnt_q[k] != ccount(k);
      end
    end
    // Feedback is never accepted during INIT, so it cannot collide with init pushes.
    if (fb_acc && fb_ok) begin
      push[fb_k]      = 1'b1;
      push_data[fb_k] = bus.feedback_addr_i;
    end
    for (int k = 0; k < NC; k++)
      cnt_d[k] = cnt_q[k] + CNT_WIDTH'(push[k]) - CNT_WIDTH'(pop[k]);

    wv_d = wv_q; waddr_d = waddr_q; wlen_d = wlen_q; wtag_d = wtag_q;
    if (pkt_acc) begin
      wv_d = sel_ok;
      if (sel_ok) begin
        waddr_d = sel_addr;
        wlen_d  = sel_len;
        wtag_d  = bus.pkt_tag_i;
      end
    end else if (bus.write_ready_i) begin
      wv_d = 1'b0;
    end
    drop_d = sat_inc(drop_q, pkt_acc && !sel_ok);
    fbk_d  = sat_inc(fbk_q, pkt_acc && sel_ok && sel_fb);
    bad_d  = sat_inc(bad_q, fb_acc && !fb_ok);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_INIT; init_cnt_q <= '0; init_addr_q <= start_a; cnt_q <= '0;
      wv_q <= 1'b0; waddr_q <= '0; wlen_q <= '0; wtag_q <= '0;
      drop_q <= '0; fbk_q <= '0; bad_q <= '0;
    end else begin
      state_q <= state_d; init_cnt_q <= init_cnt_d; init_addr_q <= init_addr_d; cnt_q <= cnt_d;
      wv_q <= wv_d; waddr_q <= waddr_d; wlen_q <= wlen_d; wtag_q <= wtag_d;
      drop_q <= drop_d; fbk_q <= fbk_d; bad_q <= bad_d;
    end
  end

  assign bus.write_valid_o = wv_q;
  assign bus.write_addr_o  = waddr_q;
  assign bus.write_len_o   = wlen_q;
  assign bus.write_tag_o   = wtag_q;
  assign free_count_o      = cnt_q;
  assign dropped_pkts_o    = drop_q;
  assign fallback_pkts_o   = fbk_q;
  assign bad_feedback_o    = bad_q;
endmodule

// File: tb/tb_pspin_pkt_alloc_mc.sv
// Randomized bench for pspin_pkt_alloc_mc against a queue-based free-list model;
// a second small instance without fallback covers the drop-on-exhaustion path.
module tb_pspin_pkt_alloc_mc;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  pspin_pkt_alloc_mc_if #(.ADDR_WIDTH(32), .LEN_WIDTH(20), .TAG_WIDTH(32)) bus ();
  pspin_pkt_alloc_mc_if #(.ADDR_WIDTH(32), .LEN_WIDTH(20), .TAG_WIDTH(32)) bus2 ();

  logic        init_done, init_done2;
  logic [63:0] free_count, free_count2;
  logic [31:0] dropped, fallback, bad, dropped2, fallback2, bad2;

  pspin_pkt_alloc_mc u_dut (
    .clk(clk), .rstn(rstn), .bus(bus), .init_done_o(init_done), .free_count_o(free_count),
    .dropped_pkts_o(dropped), .fallback_pkts_o(fallback), .bad_feedback_o(bad)
  );
  pspin_pkt_alloc_mc #(.CLASS_COUNT({16'd2, 16'd2, 16'd2, 16'd2}), .FALLBACK_EN(1'b0)) u_nofb (
    .clk(clk), .rstn(rstn), .bus(bus2), .init_done_o(init_done2), .free_count_o(free_count2),
    .dropped_pkts_o(dropped2), .fallback_pkts_o(fallback2), .bad_feedback_o(bad2)
  );

  int n_run = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: class geometry from the size/count tables, one queue per free list.
  int unsigned SZ [4] = '{64, 256, 1536, 4096};
  int unsigned CT [4] = '{2048, 512, 256, 32};
  logic [31:0] ST [5];
  logic [31:0] m_q [4][$];
  logic [31:0] outs [$];
  bit          m_init, m_wv;
  logic [31:0] m_addr, m_tag, m_drop, m_fbk, m_bad;
  int unsigned m_len;

  task automatic model_reset();
    ST[0] = 32'h1c100000;
    for (int k = 0; k < 4; k++) ST[k+1] = ST[k] + SZ[k] * CT[k];
    for (int k = 0; k < 4; k++) begin
      m_q[k].delete();
      for (int i = 0; i < int'(CT[k]); i++) m_q[k].push_back(ST[k] + i * SZ[k]);
    end
    outs.delete();
    m_wv = 0; m_addr = 0; m_tag = 0; m_len = 0; m_drop = 0; m_fbk = 0; m_bad = 0;
  endtask

  // One clock on the main DUT: drive at negedge, predict, compare after the edge.
  task automatic step(input bit pv, input int unsigned len, input logic [31:0] tag,
                      input bit fv, input logic [31:0] fa, input bit wr);
    bit pr, acc, ok;
    int pref, sel, fk;
    bus.pkt_valid_i = pv; bus.pkt_len_i = len[19:0]; bus.pkt_tag_i = tag;
    bus.feedback_valid_i = fv; bus.feedback_addr_i = fa; bus.write_ready_i = wr;
    #1;
    pr = m_init && (!m_wv || wr);
    chk("pkt_ready", bus.pkt_ready_o, pr);
    chk("fb_ready", bus.feedback_ready_o, m_init);
    acc = pv && pr;
    pref = -1; sel = -1; fk = -1; ok = 0;
    if (acc) begin
      for (int k = 3; k >= 0; k--) if (SZ[k] >= len) pref = k;
      if (pref >= 0) begin
        if (m_q[pref].size() > 0) sel = pref;
        else for (int k = 3; k > pref; k--) if (m_q[k].size() > 0) sel = k;
      end
    end
    if (fv && m_init) begin
      for (int k = 0; k < 4; k++) if (fa >= ST[k] && fa < ST[k+1]) fk = k;
      ok = (fk >= 0) && ((fa - ST[fk]) % SZ[fk] == 0) && (m_q[fk].size() < int'(CT[fk]));
      if (!ok && m_bad != '1) m_bad++;
    end
    if (acc) begin
      if (sel >= 0) begin
        m_addr = m_q[sel].pop_front(); m_len = SZ[sel]; m_tag = tag; m_wv = 1;
        outs.push_back(m_addr);
        if (sel != pref && m_fbk != '1) m_fbk++;
      end else begin
        m_wv = 0;
        if (m_drop != '1) m_drop++;
      end
    end else if (wr) m_wv = 0;
    if (ok) m_q[fk].push_back(fa);
    @(posedge clk); #1;
    chk("write_valid", bus.write_valid_o, m_wv);
    if (m_wv) begin
      chk("write_addr", bus.write_addr_o, m_addr);
      chk("write_len", bus.write_len_o, m_len);
      chk("write_tag", bus.write_tag_o, m_tag);
    end
    for (int k = 0; k < 4; k++)
      chk($sformatf("free_count%0d", k), free_count[k*16 +: 16], 64'(m_q[k].size()));
    chk("dropped", dropped, m_drop);
    chk("fallback", fallback, m_fbk);
    chk("bad_feedback", bad, m_bad);
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 1);
  endtask

  task automatic wait_init();
    int n;
    bit seen;
    n = 0; seen = 0;
    while (n < 3000) begin
      @(posedge clk); #1; n++;
      if (init_done) break;
      if (bus.pkt_ready_o || bus.feedback_ready_o) seen = 1;
    end
    chk("init_cycles", n, 2048);
    chk("ready_in_init", seen, 0);
    @(negedge clk);
    model_reset();
    m_init = 1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_init_done"}, init_done, 0);
    chk({pfx, "_pkt_ready"}, bus.pkt_ready_o, 0);
    chk({pfx, "_fb_ready"}, bus.feedback_ready_o, 0);
    chk({pfx, "_write_valid"}, bus.write_valid_o, 0);
    chk({pfx, "_write_addr"}, bus.write_addr_o, 0);
    chk({pfx, "_free_count"}, free_count, 0);
    chk({pfx, "_stats"}, {dropped, fallback} | {32'd0, bad}, 0);
  endtask

  task automatic rand_step();
    int r, k;
    int unsigned len;
    logic [31:0] fa;
    bit fv;
    r = $urandom_range(0, 9);
    k = $urandom_range(0, 3);
    case (r)
      0, 1, 2: len = $urandom_range(0, 64);
      3:       len = SZ[k] + $urandom_range(0, 1);
      4, 5:    len = $urandom_range(65, 256);
      6, 7:    len = $urandom_range(257, 1536);
      8:       len = $urandom_range(1537, 4096);
      default: len = $urandom_range(4097, 8000);
    endcase
    fv = ($urandom_range(0, 1) == 1);
    fa = 0;
    if (fv) begin
      r = $urandom_range(0, 9);
      if (r < 6 && outs.size() > 0) begin
        k = $urandom_range(0, outs.size() - 1);
        fa = outs[k];
        outs.delete(k);
      end else if (r < 7) fa = ST[k] + 32'd32;
      else if (r < 8) begin
        case ($urandom_range(0, 2))
          0: fa = 32'h1c200000 + $urandom_range(0, 4095);
          1: fa = ST[4];
          default: fa = 32'h1c0fffc0;
        endcase
      end else if (m_q[k].size() > 0) fa = m_q[k][$urandom_range(0, m_q[k].size() - 1)];
      else fa = ST[k];
    end
    step($urandom_range(0, 9) < 7, len, $urandom, fv, fa, $urandom_range(0, 3) != 0);
  endtask

  logic [31:0] held;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bus.pkt_valid_i = 0; bus.pkt_len_i = 0; bus.pkt_tag_i = 0;
    bus.feedback_valid_i = 0; bus.feedback_addr_i = 0; bus.write_ready_i = 0;
    bus2.pkt_valid_i = 0; bus2.pkt_len_i = 0; bus2.pkt_tag_i = 0;
    bus2.feedback_valid_i = 0; bus2.feedback_addr_i = 0; bus2.write_ready_i = 1;
    m_init = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rstn = 1;
    wait_init();
    chk("free_after_init", free_count, {16'd32, 16'd256, 16'd512, 16'd2048});

    // One packet per class, ready held high.
    step(1, 60, 32'hA0, 0, 0, 1);
    chk("addr_c0", bus.write_addr_o, 32'h1c100000); chk("len_c0", bus.write_len_o, 64);
    step(1, 200, 32'hA1, 0, 0, 1);
    chk("addr_c1", bus.write_addr_o, 32'h1c120000); chk("len_c1", bus.write_len_o, 256);
    step(1, 1500, 32'hA2, 0, 0, 1);
    chk("addr_c2", bus.write_addr_o, 32'h1c140000); chk("len_c2", bus.write_len_o, 1536);
    step(1, 4000, 32'hA3, 0, 0, 1);
    chk("addr_c3", bus.write_addr_o, 32'h1c1a0000); chk("tag_c3", bus.write_tag_o, 32'hA3);

    // Exhaust class 1, then the next 200-byte packet falls back to class 2.
    while (m_q[1].size() > 0) step(1, 200, $urandom, 0, 0, 1);
    chk("class1_empty", free_count[31:16], 0);
    step(1, 200, 32'hB0, 0, 0, 1);
    chk("fallback_addr", bus.write_addr_o, 32'h1c140600);
    chk("fallback_len", bus.write_len_o, 1536);
    chk("fallback_cnt", fallback, 1);
    step(1, 5000, 32'hB1, 0, 0, 1);
    chk("oversize_valid", bus.write_valid_o, 0);
    chk("oversize_drop", dropped, 1);

    // Releases: two good, then misaligned, out of range and a duplicate on a full class.
    step(1, 60, 32'hC0, 0, 0, 1);
    chk("addr_c0_second", bus.write_addr_o, 32'h1c100040);
    step(0, 0, 0, 1, 32'h1c100040, 1);
    chk("release_count", free_count[15:0], 2047);
    step(0, 0, 0, 1, 32'h1c100000, 1);
    step(0, 0, 0, 1, 32'h1c100020, 1);
    step(0, 0, 0, 1, 32'h1c200000, 1);
    step(0, 0, 0, 1, 32'h1c100000, 1);
    chk("bad_feedback_cnt", bad, 3);
    chk("full_count", free_count[15:0], 2048);

    // Simultaneous allocate and release in class 0.
    step(1, 10, 32'hC1, 1, 32'h1c100040, 1);
    step(1, 10, 32'hC2, 1, 32'h1c100080, 1);

    // Backpressure: outputs held and no accept while the DMA stalls.
    idle();
    step(1, 100, 32'hD0, 0, 0, 0);
    held = bus.write_addr_o;
    repeat (3) step(1, 300, 32'hD1, 0, 0, 0);
    chk("bp_ready", bus.pkt_ready_o, 0);
    chk("bp_addr_stable", bus.write_addr_o, held);
    chk("bp_tag_stable", bus.write_tag_o, 32'hD0);

    repeat (4000) rand_step();

    // Fallback disabled: exhausting class 1 drops the next packet.
    idle();
    chk("nofb_free", free_count2, {16'd2, 16'd2, 16'd2, 16'd2});
    bus2.pkt_valid_i = 1; bus2.pkt_len_i = 200; bus2.pkt_tag_i = 32'hE0;
    idle();
    chk("nofb_addr0", bus2.write_addr_o, 32'h1c100080);
    idle();
    chk("nofb_addr1", bus2.write_addr_o, 32'h1c100180);
    idle();
    bus2.pkt_valid_i = 0;
    chk("nofb_valid", bus2.write_valid_o, 0);
    chk("nofb_drop", dropped2, 1);
    chk("nofb_fallback", fallback2, 0);

    // Mid-stream reset: everything clears and INIT replays from the region start.
    step(1, 60, 32'hF0, 0, 0, 0);
    rstn = 0;
    @(posedge clk); #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rstn = 1;
    m_init = 0;
    wait_init();
    step(1, 60, 32'hF1, 0, 0, 1);
    chk("addr_after_reset", bus.write_addr_o, 32'h1c100000);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
